// File: rtl/morse_code_player_pkg.sv
// rtl/morse_code_player_pkg.sv - shared states, timing multipliers and Morse pattern table
package morse_code_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_ELEM_ON, ST_ELEM_GAP, ST_CHAR_GAP, ST_WORD_GAP
  } player_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS = 7;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // {len[2:0], bits[4:0]}, elements left-aligned MSB-first, 1 = dash; len 0 = ignored byte.
  function automatic logic [7:0] morse_lookup(input logic [7:0] ch);
    logic [7:0] c;
    c = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
    case (c)
      "A": return {3'd2, 5'b01000};  "B": return {3'd4, 5'b10000};
      "C": return {3'd4, 5'b10100};  "D": return {3'd3, 5'b10000};
      "E": return {3'd1, 5'b00000};  "F": return {3'd4, 5'b00100};
      "G": return {3'd3, 5'b11000};  "H": return {3'd4, 5'b00000};
      "I": return {3'd2, 5'b00000};  "J": return {3'd4, 5'b01110};
      "K": return {3'd3, 5'b10100};  "L": return {3'd4, 5'b01000};
      "M": return {3'd2, 5'b11000};  "N": return {3'd2, 5'b10000};
      "O": return {3'd3, 5'b11100};  "P": return {3'd4, 5'b01100};
      "Q": return {3'd4, 5'b11010};  "R": return {3'd3, 5'b01000};
      "S": return {3'd3, 5'b00000};  "T": return {3'd1, 5'b10000};
      "U": return {3'd3, 5'b00100};  "V": return {3'd4, 5'b00010};
      "W": return {3'd3, 5'b01100};  "X": return {3'd4, 5'b10010};
      "Y": return {3'd4, 5'b10110};  "Z": return {3'd4, 5'b11000};
      "0": return {3'd5, 5'b11111};  "1": return {3'd5, 5'b01111};
      "2": return {3'd5, 5'b00111};  "3": return {3'd5, 5'b00011};
      "4": return {3'd5, 5'b00001};  "5": return {3'd5, 5'b00000};
      "6": return {3'd5, 5'b10000};  "7": return {3'd5, 5'b11000};
      "8": return {3'd5, 5'b11100};  "9": return {3'd5, 5'b11110};
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, mid-bit sampling, LSB first
module uart_receiver
  import morse_code_player_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic          rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= RX_IDLE;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rxd_meta_d = RxD;
    rxd_sync_d = rxd_meta_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    rx_valid   = 1'b0;
    rx_error   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxd_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          rx_valid = rxd_sync_q;
          rx_error = !rxd_sync_q;
          state_d  = rxd_sync_q ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT_HIGH: if (rxd_sync_q) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data = shift_q;

endmodule

// File: rtl/morse_code_player.sv
// rtl/morse_code_player.sv - UART bytes into a small FIFO, played back as timed Morse on the buzzers
module morse_code_player
  import morse_code_player_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int UNIT_CLKS    = 10000000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic RxD,
  output logic dot_buzzer,
  output logic dash_buzzer,
  output logic busy,
  output logic char_done,
  output logic rx_error,
  output logic overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] DOT_LAST   = 32'(UNIT_CLKS * DOT_UNITS - 1);
  localparam logic [31:0] DASH_LAST  = 32'(UNIT_CLKS * DASH_UNITS - 1);
  localparam logic [31:0] CHAR_LAST  = 32'(UNIT_CLKS * CHAR_GAP_UNITS - 1);
  localparam logic [31:0] WORD_LAST  = 32'(UNIT_CLKS * WORD_GAP_UNITS - 1);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);

  logic [7:0] rx_data;
  logic       rx_valid;

  uart_receiver #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .Reset    (Reset),
    .RxD      (RxD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error)
  );

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [AW:0]   count_q, count_d;
  logic          fifo_empty, fifo_full, push, pop;
  logic [7:0]    fifo_head;

  player_state_e state_q, state_d;
  logic [2:0]    len_q, len_d;
  logic [4:0]    bits_q, bits_d;
  logic          space_q, space_d;
  logic [31:0]   cnt_q, cnt_d, elem_last;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_head  = fifo_mem_q[rd_idx_q];

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      len_q    <= '0;
      bits_q   <= '0;
      space_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      state_q  <= state_d;
      len_q    <= len_d;
      bits_q   <= bits_d;
      space_q  <= space_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_idx_q] <= rx_data;
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  always_comb begin
    push     = rx_valid && (!fifo_full || pop);
    overflow = rx_valid && fifo_full && !pop;
    wr_idx_d = wr_idx_q + AW'(push);
    rd_idx_d = rd_idx_q + AW'(pop);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // The pattern is captured at pop time because the head moves on once popped.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    bits_d    = bits_q;
    space_d   = space_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    char_done = 1'b0;
    elem_last = bits_q[4] ? DASH_LAST : DOT_LAST;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop             = 1'b1;
          {len_d, bits_d} = morse_lookup(fifo_head);
          space_d         = (fifo_head == ASCII_SPACE);
          state_d         = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d = '0;
        if (space_q)            state_d = ST_WORD_GAP;
        else if (len_q == 3'd0) state_d = ST_IDLE;
        else                    state_d = ST_ELEM_ON;
      end
      ST_ELEM_ON: begin
        if (cnt_q == elem_last) begin
          cnt_d   = '0;
          bits_d  = bits_q << 1;
          len_d   = len_q - 3'd1;
          state_d = (len_q > 3'd1) ? ST_ELEM_GAP : ST_CHAR_GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_ELEM_GAP: begin
        if (cnt_q == DOT_LAST) begin
          cnt_d   = '0;
          state_d = ST_ELEM_ON;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (cnt_q == ((state_q == ST_CHAR_GAP) ? CHAR_LAST : WORD_LAST)) begin
          cnt_d     = '0;
          char_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dot_buzzer  = (state_q == ST_ELEM_ON) && !bits_q[4];
  assign dash_buzzer = (state_q == ST_ELEM_ON) &&  bits_q[4];
  assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_code_player.sv
// tb/tb_morse_code_player.sv - directed bench for morse_code_player
module tb_morse_code_player;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rxd_a, dot_a, dash_a, busy_a, done_a, err_a, ovf_a;
  logic rst_b, rxd_b, dot_b, dash_b, busy_b, done_b, err_b, ovf_b;

  morse_code_player #(.CLKS_PER_BIT(CPB), .UNIT_CLKS(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .Reset(rst_a), .RxD(rxd_a), .dot_buzzer(dot_a), .dash_buzzer(dash_a),
    .busy(busy_a), .char_done(done_a), .rx_error(err_a), .overflow(ovf_a)
  );

  morse_code_player #(.CLKS_PER_BIT(CPB), .UNIT_CLKS(64), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .Reset(rst_b), .RxD(rxd_b), .dot_buzzer(dot_b), .dash_buzzer(dash_b),
    .busy(busy_b), .char_done(done_b), .rx_error(err_b), .overflow(ovf_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Event log for dut_a: 1000+len dot, 2000+len dash, 3000+len silence before an element,
  // 4000+len silence up to and including a char_done cycle.
  int   ev_q[$];
  int   prev_sym, run_len, silent, armed, err_cnt, busy_cnt, ovf_cnt;
  logic mon_clr = 1'b0;
  int   b_dot_rise, b_dash_rise, b_dot_len, b_dash_len, b_dot_run, b_dash_run;
  int   b_ovf, b_err, b_done, b_act, b_busy;
  logic b_prev_dot, b_prev_dash;
  logic b_clr = 1'b0;

  initial begin
    int sym;
    forever begin
      @(negedge clk);
      sym = dot_a ? 1 : (dash_a ? 2 : 0);
      if (mon_clr) begin
        ev_q.delete();
        prev_sym = 0; run_len = 0; silent = 0; armed = 0;
        err_cnt = 0; busy_cnt = 0; ovf_cnt = 0;
      end else begin
        if (err_a)  err_cnt++;
        if (busy_a) busy_cnt++;
        if (ovf_a)  ovf_cnt++;
        if (sym != 0) begin
          if (prev_sym == 0) begin
            if (armed != 0) ev_q.push_back(3000 + silent);
            run_len = 1;
          end else if (sym == prev_sym) begin
            run_len++;
          end else begin
            ev_q.push_back(prev_sym * 1000 + run_len);
            run_len = 1;
          end
          armed = 1;
        end else begin
          if (prev_sym != 0) begin
            ev_q.push_back(prev_sym * 1000 + run_len);
            silent = 0;
          end
          silent++;
          if (done_a) begin
            ev_q.push_back(4000 + silent);
            silent = 0;
            armed  = 1;
          end
        end
        prev_sym = sym;
      end
      if (b_clr) begin
        b_dot_rise = 0; b_dash_rise = 0; b_dot_len = 0; b_dash_len = 0;
        b_dot_run = 0; b_dash_run = 0; b_ovf = 0; b_err = 0; b_done = 0;
        b_act = 0; b_busy = 0; b_prev_dot = dot_b; b_prev_dash = dash_b;
      end else begin
        if (dot_b && !b_prev_dot)   b_dot_rise++;
        if (dash_b && !b_prev_dash) b_dash_rise++;
        if (dot_b)  b_dot_run++;
        else if (b_prev_dot) begin b_dot_len = b_dot_run; b_dot_run = 0; end
        if (dash_b) b_dash_run++;
        else if (b_prev_dash) begin b_dash_len = b_dash_run; b_dash_run = 0; end
        if (ovf_b)  b_ovf++;
        if (err_b)  b_err++;
        if (done_b) b_done++;
        if (busy_b) b_busy++;
        if (dot_b || dash_b) b_act++;
        b_prev_dot  = dot_b;
        b_prev_dash = dash_b;
      end
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1; b_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0; b_clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic to_b);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (to_b) rxd_b = fr[i]; else rxd_a = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (to_b) rxd_b = 1'b1; else rxd_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input logic on_b, input string tag);
    int t;
    t = 0;
    repeat (4) @(posedge clk);
    #1;
    while ((on_b ? busy_b : busy_a) && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 4000) check({tag, ".timeout"}, 1, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string tag, input int exp[$]);
    check({tag, ".n_events"}, ev_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s.ev%0d", tag, i), (i < ev_q.size()) ? ev_q[i] : -1, exp[i]);
  endtask

  initial begin
    int exp_q[$];
    rst_a = 1'b1; rxd_a = 1'b1; rst_b = 1'b1; rxd_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.dot", dot_a, 0);
    check("rst.dash", dash_a, 0);
    check("rst.busy", busy_a, 0);
    check("rst.char_done", done_a, 0);
    check("rst.rx_error", err_a, 0);
    check("rst.overflow", ovf_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    clear_mon();
    send_byte(8'h45, 1'b1, 1'b0);
    wait_idle(1'b0, "E");
    exp_q = '{1004, 4012};
    chk_seq("E", exp_q);

    exp_q = '{1004, 3004, 2012, 4012};
    clear_mon();
    send_byte(8'h61, 1'b1, 1'b0);
    wait_idle(1'b0, "a");
    chk_seq("a", exp_q);
    clear_mon();
    send_byte(8'h41, 1'b1, 1'b0);
    wait_idle(1'b0, "A");
    chk_seq("A", exp_q);

    clear_mon();
    send_byte(8'h30, 1'b1, 1'b0);
    send_byte(8'h20, 1'b1, 1'b0);
    send_byte(8'h45, 1'b1, 1'b0);
    wait_idle(1'b0, "0_E");
    exp_q = '{2012, 3004, 2012, 3004, 2012, 3004, 2012, 3004, 2012, 4012, 4030, 3002, 1004, 4012};
    chk_seq("0_E", exp_q);

    clear_mon();
    send_byte(8'h54, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("err.rx_error_pulses", err_cnt, 1);
    check("err.busy_cycles", busy_cnt, 0);
    check("err.events", ev_q.size(), 0);
    clear_mon();
    send_byte(8'h54, 1'b1, 1'b0);
    wait_idle(1'b0, "T");
    exp_q = '{2012, 4012};
    chk_seq("T", exp_q);
    check("T.rx_error_pulses", err_cnt, 0);
    check("T.overflow_pulses", ovf_cnt, 0);

    clear_mon();
    send_byte(8'h54, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'h45, 1'b1, 1'b1);
    wait_idle(1'b1, "ovf");
    check("ovf.overflow_pulses", b_ovf, 1);
    check("ovf.dash_count", b_dash_rise, 1);
    check("ovf.dash_len", b_dash_len, 192);
    check("ovf.dot_count", b_dot_rise, 4);
    check("ovf.dot_len", b_dot_len, 64);
    check("ovf.char_done_pulses", b_done, 5);
    check("ovf.rx_error_pulses", b_err, 0);

    clear_mon();
    send_byte(8'h54, 1'b1, 1'b1);
    send_byte(8'h45, 1'b1, 1'b1);
    send_byte(8'h45, 1'b1, 1'b1);
    check("rst_mid.dash_before", dash_b, 1);
    check("rst_mid.busy_before", busy_b, 1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    check("rst_mid.dash_at_edge", dash_b, 0);
    @(posedge clk); #1;
    check("rst_mid.busy_next", busy_b, 0);
    clear_mon();
    repeat (800) @(posedge clk);
    #1;
    check("rst_mid.buzzer_cycles", b_act, 0);
    check("rst_mid.busy_cycles", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/morse_code_player.md
Name: morse_code_player

Overview:
Receive-side counterpart of the keyed-Morse-to-UART path. The block receives ASCII bytes on a UART RxD line, 8N1, LSB first. It buffers them in a 4-deep FIFO, then plays each character back as timed Morse on the same dot/dash buzzer outputs the sound generator drives. It sits between the board RX pin and the buzzers, and lets a host send text that the board sounds out.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud).
UNIT_CLKS, 10000000, clk cycles per Morse time unit (100 ms at 100 MHz).
FIFO_DEPTH, 4, byte buffer entries; power of 2 only.

Ports:
clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
RxD  input  1  UART serial in; idles high; asynchronous to clk
dot_buzzer  output  1  high while a dot element sounds
dash_buzzer  output  1  high while a dash element sounds
busy  output  1  high when FIFO is non-empty or player is not IDLE
char_done  output  1  1-cycle pulse when a character's or space's trailing gap ends
rx_error  output  1  1-cycle pulse when a frame has a bad stop bit
overflow  output  1  1-cycle pulse when a received byte is dropped because the FIFO is full

Behaviour:
- Reset (clk edge with Reset=1): all outputs 0. FIFO emptied. Receiver returns to IDLE and discards any partial frame. Player returns to IDLE. Buzzers are low from the first edge at which Reset is sampled.
- RX: RxD passes through a 2-flop synchronizer. A falling edge starts a frame.
  - Start bit is re-checked at CLKS_PER_BIT/2; if it is high, the frame is a false start and the receiver returns to IDLE silently.
  - 8 data bits are sampled at mid-bit, LSB first, then the stop bit is sampled at mid-bit.
  - Stop bit = 1: the byte is written to the FIFO on that cycle. If the FIFO is full, the byte is dropped and overflow pulses instead.
  - Stop bit = 0: byte discarded, rx_error pulses, and the receiver waits for RxD high before re-arming.
- FIFO: a write and a pop on the same cycle are both honoured; when full, a same-cycle pop makes room, so no overflow.
- Lookup (combinational from FIFO head):
  - 'A'-'Z' and 'a'-'z' map to the same pattern (case is folded).
  - '0'-'9' are 5-element codes.
  - 0x20 is a word space.
  - Every other byte is popped and ignored, with no gap and no char_done.
  - Pattern format: 3-bit length (1..5) plus a 5-bit element field, MSB-first, 1 = dash.
- Player FSM states: IDLE, LOAD, ELEM_ON, ELEM_GAP, CHAR_GAP, WORD_GAP.
  - IDLE: if FIFO non-empty, pop and go to LOAD.
  - LOAD (1 cycle): register pattern, length and element index; go to ELEM_ON, to WORD_GAP for a space, or to IDLE for an ignored byte.
  - ELEM_ON: exactly one buzzer is high. Dot lasts UNIT_CLKS cycles; dash lasts 3*UNIT_CLKS. Then go to ELEM_GAP if elements remain, else CHAR_GAP.
  - ELEM_GAP: both buzzers low for UNIT_CLKS, then ELEM_ON for the next element.
  - CHAR_GAP: low for 3*UNIT_CLKS.
  - WORD_GAP: low for 7*UNIT_CLKS.
  - At the end of CHAR_GAP or WORD_GAP, char_done pulses and the FSM goes to IDLE.
- Latency: from IDLE with an empty FIFO, the buzzer rises 3 clk edges after the cycle the FIFO write occurs (FIFO write, pop, LOAD).
- Back-to-back: the next character's first element starts 2 cycles after char_done (IDLE, LOAD). The gap inflation of 2 clks is accepted.
- Duration counter: 32 bits wide, and must hold 7*UNIT_CLKS-1 without overflow.
- busy: combinational from FIFO state and FSM state.

Decomposition:
- Shared include morse_defs.vh holds:
  - FSM state localparams;
  - the pattern-table function or case constants, {len[2:0], bits[4:0]} per character, reused by the translator;
  - unit multipliers DOT=1, DASH=3, CHAR_GAP=3, WORD_GAP=7.
- Sub-module uart_receiver(clk, Reset, RxD, rx_data[7:0], rx_valid, rx_error), parameterized by CLKS_PER_BIT.
- The FIFO and the player FSM live in morse_code_player.

Test Plan (CLKS_PER_BIT=4, UNIT_CLKS=4):
- Send 0x45 'E' -> dot_buzzer high exactly 4 clks; then 12 clks silent; char_done pulses once; dash_buzzer never rises; busy then falls.
- Send 0x61 'a' -> dot 4 clks, gap 4, dash 12 clks, then 12 silent, then char_done; output identical to 'A'.
- Send "0 E" (0x30, 0x20, 0x45) -> five 12-clk dashes separated by 4-clk gaps, 12-clk char gap, 28-clk word gap, then a dot; char_done pulses 3 times.
- Frame 0x54 with stop bit driven 0 -> rx_error pulses 1 clk; no FIFO write; buzzers stay low; next valid 'T' plays a 12-clk dash.
- While 'T' plays, send 5 bytes 'E' back-to-back -> first 4 are stored, overflow pulses on the 5th; exactly 4 dots follow 'T'.
- Assert Reset for 1 clk mid-dash with 2 bytes queued -> dash_buzzer low on that edge; busy=0 the next cycle; no further buzzer activity.
